// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 encodings and access sizes shared by the data memory
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] BYTE_N = 3'd1;
  localparam logic [2:0] HALF_N = 3'd2;
  localparam logic [2:0] WORD_N = 3'd4;
endpackage

// File: rtl/dmem_load_extend.sv
// load_extend: sign/zero-extends the assembled little-endian bytes according to funct3
module load_extend
  import dmem_pkg::*;
#(
  parameter int f3    = 3,
  parameter int vlen  = 32,
  parameter int width = 8
) (
  input  logic [4*width-1:0] i_bytes,
  input  logic [f3-1:0]      i_funct3,
  output logic [vlen-1:0]    o_rd
);
  logic [width-1:0]   w_b;
  logic [2*width-1:0] w_h;
  assign w_b = i_bytes[width-1:0];
  assign w_h = i_bytes[2*width-1:0];
  always_comb
    o_rd = i_funct3 == F3_B  ? {{(vlen-width){w_b[width-1]}}, w_b} :
           i_funct3 == F3_BU ? {{(vlen-width){1'b0}}, w_b} :
           i_funct3 == F3_H  ? {{(vlen-2*width){w_h[2*width-1]}}, w_h} :
           i_funct3 == F3_HU ? {{(vlen-2*width){1'b0}}, w_h} :
           i_funct3 == F3_W  ? vlen'(i_bytes) : '0;
endmodule

// File: rtl/dmem.sv
// dmem: byte-addressable RISC-V data memory, synchronous stores, combinational loads
module dmem
  import dmem_pkg::*;
#(
  parameter int f3     = 3,
  parameter int addlen = 32,
  parameter int vlen   = 32,
  parameter int width  = 8,
  parameter int len    = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [f3-1:0]     funct3,
  input  logic [addlen-1:0] address,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [vlen-1:0]   rs,
  output logic [vlen-1:0]   rd
);
  localparam int IW = $clog2(len);
  logic [width-1:0]   r_mem [len];
  logic [2:0]         w_n;
  logic [addlen:0]    w_end;
  logic               w_ok;
  logic               w_st;
  logic [IW-1:0]      w_ia [4];
  logic [4*width-1:0] w_bytes;
  logic [vlen-1:0]    w_ext;
  assign w_n   = funct3[1:0] == 2'b00 ? BYTE_N : funct3[1:0] == 2'b01 ? HALF_N : WORD_N;
  // range check on the full address, one bit wider so the last byte cannot wrap
  assign w_end = {1'b0, address} + (addlen+1)'(w_n - 3'd1);
  assign w_ok  = w_end < (addlen+1)'(len);
  assign w_st  = MemWrite && w_ok && (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign w_ia[k] = address[IW-1:0] + IW'(k);
    assign w_bytes[k*width +: width] = r_mem[w_ia[k]];
  end
  always_ff @(posedge clk)
    if (rst)
      for (int i = 0; i < len; i++) r_mem[i] <= '0;
    else if (w_st)
      for (int k = 0; k < 4; k++)
        if (k < int'(w_n)) r_mem[w_ia[k]] <= rs[k*width +: width];
  load_extend #(.f3(f3), .vlen(vlen), .width(width)) u_ext (
    .i_bytes (w_bytes),
    .i_funct3(funct3),
    .o_rd    (w_ext)
  );
  assign rd = MemRead && w_ok ? w_ext : '0;
endmodule

// File: tb/tb_dmem.sv
// tb_dmem: directed plan plus randomized loads/stores against a byte-array reference model
module tb_dmem;
  logic        clk = 0;
  logic        rst = 1;
  logic [2:0]  funct3 = 0;
  logic [31:0] address = 0;
  logic        MemRead = 0;
  logic        MemWrite = 0;
  logic [31:0] rs = 0;
  logic [31:0] rd;
  logic [7:0]  m [100];
  int          n_chk = 0;
  int          n_fail = 0;

  dmem u_dut (
    .clk(clk), .rst(rst), .funct3(funct3), .address(address),
    .MemRead(MemRead), .MemWrite(MemWrite), .rs(rs), .rd(rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f);
    return f[1:0] == 2'b00 ? 1 : f[1:0] == 2'b01 ? 2 : 4;
  endfunction

  function automatic logic [31:0] mload(input logic [2:0] f, input logic [31:0] a);
    int n;
    logic [31:0] w;
    n = nbytes(f);
    if (!(f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 0;
    if (a > 32'(100 - n)) return 0;
    w = 0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = m[a+k];
    case (f)
      3'b000:  return 32'($signed(w[7:0]));
      3'b001:  return 32'($signed(w[15:0]));
      default: return w;
    endcase
  endfunction

  task automatic mstore(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = nbytes(f);
    if (!(f inside {3'b000, 3'b001, 3'b010})) return;
    if (a > 32'(100 - n)) return;
    for (int k = 0; k < n; k++) m[a+k] = d[8*k +: 8];
  endtask

  task automatic st(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    funct3 = f; address = a; rs = d; MemWrite = 1; MemRead = 0;
    @(posedge clk); #1;
    MemWrite = 0;
    mstore(f, a, d);
  endtask

  task automatic ld(input string tag, input logic [2:0] f, input logic [31:0] a);
    funct3 = f; address = a; MemRead = 1; MemWrite = 0;
    #1 chk(tag, rd, mload(f, a));
    MemRead = 0;
  endtask

  task automatic ldx(input string tag, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] exp);
    funct3 = f; address = a; MemRead = 1; MemWrite = 0;
    #1 chk(tag, rd, exp);
    MemRead = 0;
  endtask

  task automatic rw(input string tag, input logic [2:0] f, input logic [31:0] a,
                    input logic [31:0] d);
    funct3 = f; address = a; rs = d; MemRead = 1; MemWrite = 1;
    #1 chk({tag, "_pre"}, rd, mload(f, a));
    @(posedge clk); #1;
    MemWrite = 0;
    mstore(f, a, d);
    chk({tag, "_post"}, rd, mload(f, a));
    MemRead = 0;
  endtask

  initial begin
    for (int i = 0; i < 100; i++) m[i] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    ldx("reset_lw0", 3'b010, 0, 32'h0);
    ldx("reset_lbu99", 3'b100, 99, 32'h0);

    st(3'b010, 0, 32'hAABBCCDD);
    ldx("lw0", 3'b010, 0, 32'hAABBCCDD);
    ldx("lb0", 3'b000, 0, 32'hFFFFFFDD);
    ldx("lbu0", 3'b100, 0, 32'h000000DD);
    ldx("lh0", 3'b001, 0, 32'hFFFFCCDD);
    ldx("lhu0", 3'b101, 0, 32'h0000CCDD);

    st(3'b010, 8, 32'h11223344);
    st(3'b000, 9, 32'h000000EE);
    ldx("sb9_lw8", 3'b010, 8, 32'h1122EE44);
    st(3'b001, 10, 32'h00007F01);
    ldx("sh10_lw8", 3'b010, 8, 32'h7F01EE44);
    ldx("lh10", 3'b001, 10, 32'h00007F01);

    st(3'b000, 97, 32'h00000011);
    st(3'b000, 98, 32'h00000022);
    st(3'b000, 99, 32'h00000080);
    st(3'b010, 97, 32'hDEADBEEF);
    ldx("oor_b97", 3'b100, 97, 32'h11);
    ldx("oor_b98", 3'b100, 98, 32'h22);
    ldx("oor_b99", 3'b100, 99, 32'h80);
    ldx("oor_lw97", 3'b010, 97, 32'h0);
    ldx("lb99", 3'b000, 99, 32'hFFFFFF80);
    ldx("oor_lh99", 3'b101, 99, 32'h0);
    ldx("oor_huge", 3'b000, 32'hFFFFFFFF, 32'h0);

    funct3 = 3'b010; address = 0; MemRead = 0;
    #1 chk("rd_disabled", rd, 32'h0);
    st(3'b011, 0, 32'h55555555);
    ldx("f3_011_store", 3'b010, 0, 32'hAABBCCDD);
    ldx("f3_011_load", 3'b011, 0, 32'h0);

    st(3'b010, 0, 32'hDEADBEEF);
    funct3 = 3'b010; address = 0; rs = 32'h12345678; MemWrite = 1; rst = 1;
    @(posedge clk); #1;
    rst = 0; MemWrite = 0;
    for (int i = 0; i < 100; i++) m[i] = 0;
    ldx("rst_lw0", 3'b010, 0, 32'h0);
    ldx("rst_lw8", 3'b010, 8, 32'h0);

    rw("rw4", 3'b010, 4, 32'hCAFEBABE);
    chk("rw4_model", mload(3'b010, 4), 32'hCAFEBABE);

    for (int it = 0; it < 400; it++) begin
      logic [2:0]  f;
      logic [31:0] a, d;
      f = 3'($urandom_range(0, 7));
      a = $urandom_range(0, 15) == 0 ? $urandom : 32'($urandom_range(0, 103));
      d = $urandom;
      case ($urandom_range(0, 2))
        0: st(f, a, d);
        1: ld("rnd_ld", f, a);
        default: rw("rnd_rw", f, a, d);
      endcase
    end
    for (int i = 0; i < 100; i++) ld("scan_lbu", 3'b100, 32'(i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
